multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the RV32I core; sits directly upstream of the datapath and drives every control input it consumes. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, latches opcode/f3/f7 at decode, handshakes with the instruction and data memories, and traps on illegal encodings.

---
 rtl/multicycle_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for an RV32I datapath
//
// Purpose: steps each instruction through its state path, latches the decode
// fields in DECODE, handshakes with instruction/data memory and traps
// (sticky until reset) on illegal encodings.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   opcode, f3, f7             decode fields from the datapath, sampled in DECODE
//   imem_ready, dmem_ready     memory completion strobes (FETCH / MEM only)
//   if_rd, ir_en               instruction fetch request / IR load
//   pc_en, reg_wr              PC update / register write, once per instruction
//   mem_rd, mem_wr             data memory read / write request
//   wb_ctrl, alu_op            writeback source select, ALU operation
//   alu_s1, alu_s2             ALU operand selects (PC / immediate)
//   branch_ctrl                branch condition code, 7 = unconditional
//   trap                       illegal instruction, held until reset
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] f3,
  input  logic [6:0] f7,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       if_rd,
  output logic       ir_en,
  output logic       pc_en,
  output logic       reg_wr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [1:0] wb_ctrl,
  output logic [3:0] alu_op,
  output logic       alu_s1,
  output logic       alu_s2,
  output logic [2:0] branch_ctrl,
  output logic       trap
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  // C_NONE doubles as the "illegal encoding" result of classification.
  typedef enum logic [3:0] {
    C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
  } class_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_PASS = 4'd10;

  state_t     state_q, state_d;
  class_t     cls_q, cls_d;
  logic [2:0] f3_q;
  logic       sub_q;   // f7[5]: selects SUB/SRA

  function automatic class_t classify(input logic [6:0] op_v,
                                      input logic [2:0] fn3,
                                      input logic [6:0] fn7);
    class_t c;
    c = C_NONE;
    case (op_v)
      7'b0110011: begin
        if (fn7 == 7'b0000000 ||
            (fn7 == 7'b0100000 && (fn3 == 3'b000 || fn3 == 3'b101)))
          c = C_R;
      end
      7'b0010011: begin
        // Only the shift-immediates carry a funct7; other I-ALU ops ignore it.
        case (fn3)
          3'b001:  if (fn7 == 7'b0000000) c = C_I;
          3'b101:  if (fn7 == 7'b0000000 || fn7 == 7'b0100000) c = C_I;
          default: c = C_I;
        endcase
      end
      7'b0000011: begin
        if (fn3 != 3'b011 && fn3 != 3'b110 && fn3 != 3'b111) c = C_LOAD;
      end
      7'b0100011: begin
        if (fn3 == 3'b000 || fn3 == 3'b001 || fn3 == 3'b010) c = C_STORE;
      end
      7'b1100011: begin
        if (fn3 != 3'b010 && fn3 != 3'b011) c = C_BRANCH;
      end
      7'b1101111: c = C_JAL;
      7'b1100111: begin
        if (fn3 == 3'b000) c = C_JALR;
      end
      7'b0110111: c = C_LUI;
      7'b0010111: c = C_AUIPC;
      default:    c = C_NONE;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] alu_from_f3(input logic [2:0] fn3, input logic alt);
    logic [3:0] a;
    case (fn3)
      3'b000:  a = alt ? 4'd1 : 4'd0;
      3'b001:  a = 4'd2;
      3'b010:  a = 4'd3;
      3'b011:  a = 4'd4;
      3'b100:  a = 4'd5;
      3'b101:  a = alt ? 4'd7 : 4'd6;
      3'b110:  a = 4'd8;
      default: a = 4'd9;
    endcase
    return a;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cls_q   <= C_NONE;
      f3_q    <= 3'b000;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        cls_q <= cls_d;
        f3_q  <= f3;
        sub_q <= f7[5];
      end
    end
  end

  assign cls_d = classify(opcode, f3, f7);

  always_comb begin
    state_d     = state_q;
    if_rd       = 1'b0;
    ir_en       = 1'b0;
    pc_en       = 1'b0;
    reg_wr      = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    wb_ctrl     = 2'b00;
    alu_op      = ALU_ADD;
    alu_s1      = 1'b0;
    alu_s2      = 1'b0;
    branch_ctrl = 3'd0;
    trap        = 1'b0;

    // Datapath controls come only from the latched class, so they stay
    // stable across EXEC/MEM/WB regardless of what the decode inputs do.
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      case (cls_q)
        C_R: begin
          alu_op  = alu_from_f3(f3_q, sub_q);
          wb_ctrl = 2'b01;
        end
        C_I: begin
          alu_op  = alu_from_f3(f3_q, (f3_q == 3'b101) && sub_q);
          alu_s2  = 1'b1;
          wb_ctrl = 2'b01;
        end
        C_LOAD: begin
          alu_s2  = 1'b1;
          wb_ctrl = 2'b00;
        end
        C_STORE: begin
          alu_s2  = 1'b1;
        end
        C_BRANCH: begin
          alu_s1 = 1'b1;
          alu_s2 = 1'b1;
          case (f3_q)
            3'b000:  branch_ctrl = 3'd1;
            3'b001:  branch_ctrl = 3'd2;
            3'b100:  branch_ctrl = 3'd3;
            3'b101:  branch_ctrl = 3'd4;
            3'b110:  branch_ctrl = 3'd5;
            default: branch_ctrl = 3'd6;
          endcase
        end
        C_JAL: begin
          alu_s1      = 1'b1;
          alu_s2      = 1'b1;
          branch_ctrl = 3'd7;
          wb_ctrl     = 2'b10;
        end
        C_JALR: begin
          alu_s2      = 1'b1;
          branch_ctrl = 3'd7;
          wb_ctrl     = 2'b10;
        end
        C_LUI: begin
          alu_op  = ALU_PASS;
          alu_s2  = 1'b1;
          wb_ctrl = 2'b01;
        end
        C_AUIPC: begin
          alu_s1  = 1'b1;
          alu_s2  = 1'b1;
          wb_ctrl = 2'b01;
        end
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if_rd = 1'b1;
        if (imem_ready) begin
          ir_en   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = (cls_d == C_NONE) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (cls_q)
          C_BRANCH: begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end
          C_LOAD, C_STORE: state_d = S_MEM;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_rd = (cls_q == C_LOAD);
        mem_wr = (cls_q == C_STORE);
        if (dmem_ready) begin
          // A store retires straight out of MEM; a load still needs WB.
          if (cls_q == C_STORE) begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_wr  = 1'b1;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] f3 = '0;
  logic [6:0] f7 = '0;
  logic       imem_ready = 1'b1;
  logic       dmem_ready = 1'b1;
  logic       if_rd, ir_en, pc_en, reg_wr, mem_rd, mem_wr;
  logic [1:0] wb_ctrl;
  logic [3:0] alu_op;
  logic       alu_s1, alu_s2;
  logic [2:0] branch_ctrl;
  logic       trap;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .f3(f3), .f7(f7),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .if_rd(if_rd), .ir_en(ir_en), .pc_en(pc_en), .reg_wr(reg_wr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .wb_ctrl(wb_ctrl), .alu_op(alu_op),
    .alu_s1(alu_s1), .alu_s2(alu_s2), .branch_ctrl(branch_ctrl), .trap(trap)
  );

  logic [17:0] outs;
  logic [10:0] ctrl;
  assign outs = {if_rd, ir_en, pc_en, reg_wr, mem_rd, mem_wr, wb_ctrl, alu_op,
                 alu_s1, alu_s2, branch_ctrl, trap};
  assign ctrl = {alu_op, alu_s1, alu_s2, wb_ctrl, branch_ctrl};

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int         iw;   // imem wait cycles
    int         dw;   // dmem wait cycles
    bit         ill;
    int         cyc;
    logic [3:0] alu;
    logic       s1;
    logic       s2;
    logic [1:0] wb;
    logic [2:0] br;
    int         rw;
    int         mr;
    int         mw;
  } vec_t;

  vec_t vt[$];
  int passed = 0;
  int total  = 0;

  function automatic vec_t mk(logic [6:0] op, logic [2:0] fn3, logic [6:0] fn7,
                              int iw, int dw, bit ill, int cyc, logic [3:0] alu,
                              logic s1, logic s2, logic [1:0] wb, logic [2:0] br,
                              int rw, int mr, int mw);
    vec_t v;
    v.op = op; v.f3 = fn3; v.f7 = fn7; v.iw = iw; v.dw = dw; v.ill = ill;
    v.cyc = cyc; v.alu = alu; v.s1 = s1; v.s2 = s2; v.wb = wb; v.br = br;
    v.rw = rw; v.mr = mr; v.mw = mw;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL v%0d %s: got %0d expected %0d", idx, name, act, exp);
  endtask

  task automatic do_reset(input int idx);
    @(negedge clk);
    reset = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    #1 chk("reset_outs_zero", idx, int'(outs), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int ifc = 0, irc = 0, mrc = 0, mwc = 0, rwc = 0, mc = 0;
    int ovl = 0, zbad = 0, retire = 0, tbad = 0;
    logic [10:0] cap = '0;
    logic rw_pc = 1'b0, mw_pc = 1'b0;
    opcode = v.op; f3 = v.f3; f7 = v.f7;
    do_reset(idx);
    if (!v.ill) begin
      for (int c = 1; c <= 40 && retire == 0; c++) begin
        @(negedge clk);
        if (c == v.iw + 3) begin opcode = ~v.op; f3 = ~v.f3; f7 = ~v.f7; end
        if (if_rd) begin ifc++; imem_ready = (ifc > v.iw); end else imem_ready = 1'b1;
        if (mem_rd | mem_wr) begin mc++; dmem_ready = (mc > v.dw); end else dmem_ready = 1'b1;
        #1;
        irc += int'(ir_en); mrc += int'(mem_rd); mwc += int'(mem_wr); rwc += int'(reg_wr);
        if ((pc_en | reg_wr) & if_rd) ovl++;
        if ((c == v.iw + 1 || c == v.iw + 2) && (ctrl != 0 || trap)) zbad++;
        if (pc_en) begin retire = c; cap = ctrl; rw_pc = reg_wr; mw_pc = mem_wr; end
      end
      @(negedge clk);
      #1 chk("refetch_if_rd", idx, int'(if_rd), 1);
      chk("cycles", idx, retire, v.cyc);
      chk("ctrl_fields", idx, int'(cap), int'({v.alu, v.s1, v.s2, v.wb, v.br}));
      chk("fetch_ctrl_zero", idx, zbad, 0);
      chk("if_rd_cycles", idx, ifc, v.iw + 1);
      chk("ir_en_cycles", idx, irc, 1);
      chk("reg_wr_cycles", idx, rwc, v.rw);
      chk("mem_rd_cycles", idx, mrc, v.mr);
      chk("mem_wr_cycles", idx, mwc, v.mw);
      chk("reg_wr_with_pc_en", idx, int'(rw_pc), v.rw);
      chk("mem_wr_with_pc_en", idx, int'(mw_pc), (v.mw > 0) ? 1 : 0);
      chk("if_rd_overlap", idx, ovl, 0);
    end else begin
      for (int c = 1; c <= v.iw + 22; c++) begin
        @(negedge clk);
        if (c == v.iw + 3) begin opcode = 7'b0110011; f3 = 3'b000; f7 = 7'b0000000; end
        if (if_rd) begin ifc++; imem_ready = (ifc > v.iw); end else imem_ready = 1'b1;
        dmem_ready = 1'b1;
        #1;
        if (c <= v.iw + 2) begin
          if (trap) tbad++;
        end else if (outs != 18'd1) begin
          tbad++;
        end
      end
      chk("trap_hold", idx, tbad, 0);
      chk("trap_if_rd_cycles", idx, ifc, v.iw + 1);
    end
  endtask

  initial begin
    // op, f3, f7, iw, dw, ill, cyc, alu, s1, s2, wb, br, rw, mr, mw
    vt.push_back(mk(7'b0110011, 3'b000, 7'h00, 0, 0, 0, 4,  4'd0,  0, 0, 2'b01, 3'd0, 1, 0, 0)); // ADD
    vt.push_back(mk(7'b0110011, 3'b000, 7'h20, 0, 0, 0, 4,  4'd1,  0, 0, 2'b01, 3'd0, 1, 0, 0)); // SUB
    vt.push_back(mk(7'b0110011, 3'b101, 7'h20, 0, 0, 0, 4,  4'd7,  0, 0, 2'b01, 3'd0, 1, 0, 0)); // SRA
    vt.push_back(mk(7'b0110011, 3'b011, 7'h00, 0, 0, 0, 4,  4'd4,  0, 0, 2'b01, 3'd0, 1, 0, 0)); // SLTU
    vt.push_back(mk(7'b0110011, 3'b111, 7'h00, 0, 0, 0, 4,  4'd9,  0, 0, 2'b01, 3'd0, 1, 0, 0)); // AND
    vt.push_back(mk(7'b0010011, 3'b101, 7'h20, 0, 0, 0, 4,  4'd7,  0, 1, 2'b01, 3'd0, 1, 0, 0)); // SRAI
    vt.push_back(mk(7'b0010011, 3'b000, 7'h7F, 0, 0, 0, 4,  4'd0,  0, 1, 2'b01, 3'd0, 1, 0, 0)); // ADDI f7 set
    vt.push_back(mk(7'b0010011, 3'b100, 7'h55, 0, 0, 0, 4,  4'd5,  0, 1, 2'b01, 3'd0, 1, 0, 0)); // XORI
    vt.push_back(mk(7'b0000011, 3'b010, 7'h00, 0, 3, 0, 8,  4'd0,  0, 1, 2'b00, 3'd0, 1, 4, 0)); // LW wait 3
    vt.push_back(mk(7'b0000011, 3'b100, 7'h00, 0, 0, 0, 5,  4'd0,  0, 1, 2'b00, 3'd0, 1, 1, 0)); // LBU
    vt.push_back(mk(7'b0100011, 3'b010, 7'h00, 0, 0, 0, 4,  4'd0,  0, 1, 2'b00, 3'd0, 0, 0, 1)); // SW
    vt.push_back(mk(7'b0100011, 3'b001, 7'h00, 0, 2, 0, 6,  4'd0,  0, 1, 2'b00, 3'd0, 0, 0, 3)); // SH wait 2
    vt.push_back(mk(7'b1100011, 3'b001, 7'h00, 0, 0, 0, 3,  4'd0,  1, 1, 2'b00, 3'd2, 0, 0, 0)); // BNE
    vt.push_back(mk(7'b1100011, 3'b111, 7'h00, 0, 0, 0, 3,  4'd0,  1, 1, 2'b00, 3'd6, 0, 0, 0)); // BGEU
    vt.push_back(mk(7'b1101111, 3'b011, 7'h12, 0, 0, 0, 4,  4'd0,  1, 1, 2'b10, 3'd7, 1, 0, 0)); // JAL
    vt.push_back(mk(7'b1100111, 3'b000, 7'h00, 0, 0, 0, 4,  4'd0,  0, 1, 2'b10, 3'd7, 1, 0, 0)); // JALR
    vt.push_back(mk(7'b0110111, 3'b000, 7'h00, 0, 0, 0, 4,  4'd10, 0, 1, 2'b01, 3'd0, 1, 0, 0)); // LUI
    vt.push_back(mk(7'b0010111, 3'b000, 7'h00, 0, 0, 0, 4,  4'd0,  1, 1, 2'b01, 3'd0, 1, 0, 0)); // AUIPC
    vt.push_back(mk(7'b0110011, 3'b000, 7'h00, 2, 0, 0, 6,  4'd0,  0, 0, 2'b01, 3'd0, 1, 0, 0)); // ADD imem wait 2
    vt.push_back(mk(7'b0000011, 3'b000, 7'h00, 1, 1, 0, 7,  4'd0,  0, 1, 2'b00, 3'd0, 1, 2, 0)); // LB both waits
    vt.push_back(mk(7'b0110011, 3'b001, 7'h20, 0, 0, 1, 0,  4'd0,  0, 0, 2'b00, 3'd0, 0, 0, 0)); // SLL f7 0x20
    vt.push_back(mk(7'b1110011, 3'b000, 7'h00, 0, 0, 1, 0,  4'd0,  0, 0, 2'b00, 3'd0, 0, 0, 0)); // SYSTEM
    vt.push_back(mk(7'b0000011, 3'b011, 7'h00, 0, 0, 1, 0,  4'd0,  0, 0, 2'b00, 3'd0, 0, 0, 0)); // load f3 011
    vt.push_back(mk(7'b0100011, 3'b100, 7'h00, 0, 0, 1, 0,  4'd0,  0, 0, 2'b00, 3'd0, 0, 0, 0)); // store f3 100
    vt.push_back(mk(7'b1100011, 3'b010, 7'h00, 1, 0, 1, 0,  4'd0,  0, 0, 2'b00, 3'd0, 0, 0, 0)); // branch f3 010
    vt.push_back(mk(7'b1100111, 3'b001, 7'h00, 0, 0, 1, 0,  4'd0,  0, 0, 2'b00, 3'd0, 0, 0, 0)); // JALR f3 001
    vt.push_back(mk(7'b0110011, 3'b000, 7'h01, 0, 0, 1, 0,  4'd0,  0, 0, 2'b00, 3'd0, 0, 0, 0)); // R f7 0x01
    vt.push_back(mk(7'b0010011, 3'b001, 7'h20, 0, 0, 1, 0,  4'd0,  0, 0, 2'b00, 3'd0, 0, 0, 0)); // SLLI f7 0x20

    for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);

    // Reset while a store waits in MEM: request drops with reset, no retire.
    begin
      int pcs = 0;
      opcode = 7'b0100011; f3 = 3'b010; f7 = 7'h00;
      do_reset(100);
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        #1 pcs += int'(pc_en);
      end
      chk("store_mem_wr_before_reset", 100, int'(mem_wr), 1);
      #2 reset = 1'b1;
      #1 chk("store_reset_outs_zero", 100, int'(outs), 0);
      dmem_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        #1 pcs += int'(pc_en);
      end
      chk("store_no_pc_en", 100, pcs, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      #1 chk("fetch_after_reset", 100, int'(if_rd), 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
